data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL have parameter LINES, default 8, the number of direct-mapped lines (power of two, 2..64); IDX_W = log2(LINES), TAG_W = 28 - IDX_W.
REQ-002 The block SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port proc_read  input  1  core load request, held stable while proc_stall=1.
REQ-005 The block SHALL have port proc_write  input  1  core store request, held stable while proc_stall=1.
REQ-006 The block SHALL have port proc_addr  input  30  word address {tag, index, offset[1:0]}.
REQ-007 The block SHALL have port proc_wdata  input  32  store data.
REQ-008 The block SHALL have port proc_rdata  output  32  load data, combinational.
REQ-009 The block SHALL have port proc_stall  output  1  request not completing this cycle, combinational.
REQ-010 The block SHALL have port mem_read  output  1  block fetch request.
REQ-011 The block SHALL have port mem_write  output  1  block write-back request.
REQ-012 The block SHALL have port mem_addr  output  28  block address.
REQ-013 The block SHALL have port mem_wdata  output  128  victim block, word 0 in bits [31:0].
REQ-014 The block SHALL have port mem_rdata  input  128  fill block, word 0 in bits [31:0].
REQ-015 The block SHALL have port mem_ready  input  1  single-cycle pulse marking completion of the outstanding memory request.

Function
REQ-016 Each line SHALL hold valid, dirty, a TAG_W-bit tag and 4x32-bit data; the policy SHALL be write-back, write-allocate.
REQ-017 The FSM SHALL have states IDLE, WRITEBACK and ALLOCATE; mem_read=1 only in ALLOCATE and mem_write=1 only in WRITEBACK (Moore outputs).
REQ-018 In IDLE, hit = (proc_read|proc_write) & valid[index] & (tag[index]==proc_addr[29:IDX_W+2]).
REQ-019 On a hit, proc_stall SHALL be 0 in the same cycle.
REQ-020 On a read hit, proc_rdata SHALL be the word selected by the offset.
REQ-021 On a write hit, the block SHALL write proc_wdata into that word and set dirty at the clock edge.
REQ-022 proc_rdata SHALL always show the addressed word of the indexed line, including on a miss.
REQ-023 On a miss in IDLE, proc_stall SHALL be 1 combinationally; the next state SHALL be WRITEBACK if valid&dirty, else ALLOCATE.
REQ-024 In WRITEBACK, mem_addr SHALL be {stored tag, index} and mem_wdata the line data; on mem_ready the FSM SHALL go to ALLOCATE.
REQ-025 In ALLOCATE, mem_addr SHALL be proc_addr[29:2]; on mem_ready the block SHALL load mem_rdata, the tag, valid=1 and dirty=0, then go to IDLE.
REQ-026 After a fill, the held request SHALL hit in IDLE one cycle after mem_ready, so a clean miss costs (memory wait + 2) stall cycles.
REQ-027 proc_stall SHALL be 1 in every WRITEBACK and ALLOCATE cycle.
REQ-028 proc_read and proc_write both high SHALL be treated as a write.
REQ-029 With no request, proc_stall SHALL be 0 and no state SHALL change.
REQ-030 mem_ready in IDLE SHALL be ignored.
REQ-031 A started miss SHALL complete even if the request drops.
REQ-032 When idle, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, all valid and dirty bits 0, and mem_read=mem_write=0, including mid-WRITEBACK or mid-ALLOCATE.
REQ-034 Data arrays and tags SHALL NOT be reset.
REQ-035 After reset, any first access SHALL miss clean.

Configuration
REQ-036 With macro DCACHE_PMU_EN defined, the block SHALL add output ports hit_cnt [31:0] and miss_cnt [31:0], reset to 0, wrapping modulo 2^32.
REQ-037 hit_cnt SHALL increment once per IDLE hit cycle; miss_cnt SHALL increment once per IDLE-to-WRITEBACK/ALLOCATE transition; fill-completion hits SHALL also count as hits.
REQ-038 Without DCACHE_PMU_EN, those ports and counters SHALL be absent and the rest of the behaviour identical.

Verification
REQ-039 Reset, then read 0x0000010 with mem_ready after 3 cycles and mem_rdata word0=0xDEADBEEF -> ALLOCATE with mem_addr=0x0000004, then proc_rdata=0xDEADBEEF with stall falling at the hit cycle.
REQ-040 Write 0x12345678 to a resident word -> no stall; a subsequent read returns 0x12345678 and dirty=1.
REQ-041 Access the same index with a different tag while the line is dirty -> WRITEBACK with old block address and data containing 0x12345678, then ALLOCATE of the new block.
REQ-042 Assert rst_n low during ALLOCATE -> mem_read drops immediately and the next access misses.
REQ-043 With DCACHE_PMU_EN, sequence miss, hit, hit -> miss_cnt=1, hit_cnt=3.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// A three-state FSM (IDLE / WRITEBACK / ALLOCATE) services misses against a
// block-wide memory port that acknowledges each request with mem_ready.
// Optional performance counters are enabled with macro DCACHE_PMU_EN.
module data_cache #(
   parameter int LINES = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          proc_read,
   input  logic          proc_write,
   input  logic [29:0]   proc_addr,
   input  logic [31:0]   proc_wdata,
   output logic [31:0]   proc_rdata,
   output logic          proc_stall,
   output logic          mem_read,
   output logic          mem_write,
   output logic [27:0]   mem_addr,
   output logic [127:0]  mem_wdata,
   input  logic [127:0]  mem_rdata,
   input  logic          mem_ready
`ifdef DCACHE_PMU_EN
   ,
   output logic [31:0]   hit_cnt,
   output logic [31:0]   miss_cnt
`endif
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 28 - IDX_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

   state_t             r_state;
   state_t             w_state_nx;

   logic [LINES-1:0]   r_valid;
   logic [LINES-1:0]   r_dirty;
   logic [TAG_W-1:0]   r_tag  [LINES];
   logic [127:0]       r_data [LINES];
   // Block address of the miss being serviced, so the refill finishes even if
   // the core drops or changes its request.
   logic [27:0]        r_maddr;

   logic               w_req;
   logic [IDX_W-1:0]   w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic [1:0]         w_off;
   logic               w_hit;
   logic               w_miss;
   logic               w_fill;
   logic [IDX_W-1:0]   w_midx;

   assign w_req  = proc_read | proc_write;
   assign w_idx  = proc_addr[IDX_W+1:2];
   assign w_tag  = proc_addr[29:IDX_W+2];
   assign w_off  = proc_addr[1:0];
   assign w_midx = r_maddr[IDX_W-1:0];
   assign w_hit  = (r_state == IDLE) & w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
   assign w_miss = (r_state == IDLE) & w_req & ~w_hit;

   // Read data always reflects the addressed word of the indexed line.
   assign proc_rdata = r_data[w_idx][{w_off, 5'd0} +: 32];

   // Next-state logic and Moore memory-port outputs.
   always_comb begin
      w_state_nx = r_state;
      proc_stall = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      w_fill     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_miss) begin
               proc_stall = 1'b1;
               w_state_nx = (r_valid[w_idx] & r_dirty[w_idx]) ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            proc_stall = 1'b1;
            mem_write  = 1'b1;
            mem_addr   = {r_tag[w_midx], w_midx};
            mem_wdata  = r_data[w_midx];
            if (mem_ready) w_state_nx = ALLOCATE;
         end
         ALLOCATE: begin
            proc_stall = 1'b1;
            mem_read   = 1'b1;
            mem_addr   = r_maddr;
            if (mem_ready) begin
               w_fill     = 1'b1;
               w_state_nx = IDLE;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // FSM state and line status bits; reset invalidates every line at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_valid <= '0;
         r_dirty <= '0;
      end else begin
         r_state <= w_state_nx;
         if (w_fill) begin
            r_valid[w_midx] <= 1'b1;
            r_dirty[w_midx] <= 1'b0;
         end else if (w_hit && proc_write) begin
            r_dirty[w_idx] <= 1'b1;
         end
      end
   end

   // Tag/data storage and miss address; deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_data[w_midx] <= mem_rdata;
         r_tag[w_midx]  <= r_maddr[27:IDX_W];
      end else if (w_hit && proc_write) begin
         r_data[w_idx][{w_off, 5'd0} +: 32] <= proc_wdata;
      end
      if (w_miss) r_maddr <= proc_addr[29:2];
   end

`ifdef DCACHE_PMU_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   // Hit cycles and miss starts, wrapping naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_hit)  r_hit_cnt  <= r_hit_cnt + 32'd1;
         if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache (LINES=8): directed scenarios plus
// randomized traffic against a line-level reference model and memory image.
module tb_data_cache;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          proc_read = 1'b0;
   logic          proc_write = 1'b0;
   logic [29:0]   proc_addr = '0;
   logic [31:0]   proc_wdata = '0;
   logic [31:0]   proc_rdata;
   logic          proc_stall;
   logic          mem_read;
   logic          mem_write;
   logic [27:0]   mem_addr;
   logic [127:0]  mem_wdata;
   logic [127:0]  mem_rdata = '0;
   logic          mem_ready = 1'b0;
`ifdef DCACHE_PMU_EN
   logic [31:0]   hit_cnt;
   logic [31:0]   miss_cnt;
`endif

   data_cache #(.LINES(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
`ifdef DCACHE_PMU_EN
      ,
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: cache lines plus backing memory image.
   bit            m_valid [8];
   bit            m_dirty [8];
   logic [24:0]   m_tag   [8];
   logic [127:0]  m_data  [8];
   logic [127:0]  mem     [logic [27:0]];
   int            m_hits = 0;
   int            m_misses = 0;

   function automatic logic [127:0] get_blk(input logic [27:0] ba);
      logic [31:0] a32;
      if (mem.exists(ba)) return mem[ba];
      a32 = {4'h0, ba};
      return {a32 * 32'h9E37_79B1, ~a32, a32 ^ 32'h5A5A_5A5A, 32'hC0DE_0000 + a32};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      m_hits   = 0;
      m_misses = 0;
   endfunction

   // One core access, serviced by a memory that answers after wt cycles.
   task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                         input logic [31:0] wd, input int wt, input string nm);
      logic [2:0]   idx;
      logic [24:0]  tg;
      int           off;
      bit           hit, wb, done;
      int           exp_stall, stalls, cnt;
      logic [27:0]  vaddr;
      logic [127:0] vdata, line;
      logic [31:0]  exp_rd;
      idx = a[4:2];
      tg  = a[29:5];
      off = int'(a[1:0]);
      hit = m_valid[idx] && (m_tag[idx] == tg);
      wb  = !hit && m_valid[idx] && m_dirty[idx];
      vaddr = {m_tag[idx], idx};
      vdata = m_data[idx];
      exp_stall = hit ? 0 : (wb ? 2 * (wt + 1) + 1 : wt + 2);
      if (!hit) begin
         m_misses++;
         if (wb) mem[vaddr] = vdata;
         m_data[idx]  = get_blk(a[29:2]);
         m_tag[idx]   = tg;
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
      end
      m_hits++;
      line   = m_data[idx];
      exp_rd = line[32*off +: 32];
      if (wr) begin
         m_data[idx][32*off +: 32] = wd;
         m_dirty[idx] = 1'b1;
      end

      @(negedge clk);
      proc_read  = rd;
      proc_write = wr;
      proc_addr  = a;
      proc_wdata = wd;
      stalls = 0;
      cnt    = 0;
      done   = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         #1;
         if (!proc_stall) begin
            done = 1'b1;
         end else begin
            stalls++;
            if (mem_read || mem_write) begin
               if (cnt == 0) begin
                  n_checks++;
                  if (mem_write) begin
                     if (!wb || mem_read || mem_addr !== vaddr || mem_wdata !== vdata) begin
                        n_fail++;
                        $display("FAIL %s writeback: addr %h data %h, required addr %h data %h (wb expected %0d)",
                                 nm, mem_addr, mem_wdata, vaddr, vdata, wb);
                     end
                  end else begin
                     if (mem_addr !== a[29:2]) begin
                        n_fail++;
                        $display("FAIL %s allocate addr: got %h required %h", nm, mem_addr, a[29:2]);
                     end
                  end
               end
               if (cnt == wt) begin
                  mem_ready = 1'b1;
                  if (mem_read) mem_rdata = get_blk(mem_addr);
                  cnt = 0;
               end else begin
                  cnt++;
               end
            end
            @(negedge clk);
            mem_ready = 1'b0;
         end
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s timeout: stall still high after %0d cycles, required release", nm, stalls);
      end
      n_checks++;
      if (stalls != exp_stall) begin
         n_fail++;
         $display("FAIL %s stall_cycles: got %0d required %0d", nm, stalls, exp_stall);
      end
      if (rd && !wr && done) begin
         n_checks++;
         if (proc_rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL %s rdata: got %h required %h", nm, proc_rdata, exp_rd);
         end
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      proc_read  = 1'b0;
      proc_write = 1'b0;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      proc_read  = 1'b0;
      proc_write = 1'b0;
      mem_ready  = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || proc_stall !== 1'b0 || mem_addr !== 28'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: rd %b wr %b stall %b addr %h, required 0 0 0 0",
                  mem_read, mem_write, proc_stall, mem_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
`ifdef DCACHE_PMU_EN
      #1;
      n_checks++;
      if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_counters: hit %0d miss %0d required 0 0", hit_cnt, miss_cnt);
      end
`endif
   endtask

   // Idle cycles, including a stray mem_ready that must be ignored.
   task automatic test_idle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         proc_read  = 1'b0;
         proc_write = 1'b0;
         proc_addr  = 30'($urandom);
         mem_ready  = (i == 1);
         #1;
         n_checks++;
         if (proc_stall !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
             mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin
            n_fail++;
            $display("FAIL idle_outputs: stall %b rd %b wr %b addr %h wdata %h, required all 0",
                     proc_stall, mem_read, mem_write, mem_addr, mem_wdata);
         end
      end
      @(negedge clk);
      mem_ready = 1'b0;
   endtask

   task automatic test_directed();
      mem[28'h4] = {96'h0123_4567_89AB_CDEF_0F0F_0F0F, 32'hDEAD_BEEF};
      access(1, 0, 30'h10, 32'h0, 3, "rd_miss_fill");
      access(0, 1, 30'h10, 32'h1234_5678, 0, "wr_hit");
      access(1, 0, 30'h10, 32'h0, 0, "rd_after_wr");
      access(1, 0, 30'h30, 32'h0, 2, "dirty_conflict");
      access(1, 1, 30'h33, 32'hA5A5_0001, 1, "rd_wr_both");
      access(1, 0, 30'h33, 32'h0, 0, "rd_both_back");
      access(1, 0, 30'h10, 32'h0, 1, "rd_old_back");
      go_idle();
   endtask

   task automatic test_reset_mid_alloc();
      test_reset();
      @(negedge clk);
      proc_read = 1'b1;
      proc_addr = 30'h0000_0124;
      @(negedge clk);
      #1;
      n_checks++;
      if (mem_read !== 1'b1 || mem_addr !== 28'h49) begin
         n_fail++;
         $display("FAIL alloc_before_reset: rd %b addr %h required 1 %h", mem_read, mem_addr, 28'h49);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_drop: rd %b wr %b required 0 0", mem_read, mem_write);
      end
      @(negedge clk);
      proc_read = 1'b0;
      rst_n     = 1'b1;
      model_reset();
      access(1, 0, 30'h0000_0124, 32'h0, 1, "miss_after_reset");
      go_idle();
   endtask

   task automatic test_pmu();
`ifdef DCACHE_PMU_EN
      test_reset();
      access(1, 0, 30'h0000_0200, 32'h0, 1, "pmu_miss");
      access(1, 0, 30'h0000_0201, 32'h0, 0, "pmu_hit1");
      access(0, 1, 30'h0000_0202, 32'h7, 0, "pmu_hit2");
      go_idle();
      #1;
      n_checks++;
      if (hit_cnt !== 32'd3 || miss_cnt !== 32'd1) begin
         n_fail++;
         $display("FAIL pmu_counts: hit %0d miss %0d required 3 1", hit_cnt, miss_cnt);
      end
`endif
   endtask

   task automatic test_random();
      logic [24:0] tg;
      logic [2:0]  idx;
      logic [1:0]  off;
      bit          rd, wr;
      int          kind;
      test_reset();
      for (int i = 0; i < 150; i++) begin
         tg   = 25'($urandom_range(0, 3));
         idx  = 3'($urandom);
         off  = 2'($urandom);
         kind = $urandom_range(0, 4);
         rd   = (kind != 2);
         wr   = (kind >= 2);
         access(rd, wr, {tg, idx, off}, $urandom, $urandom_range(0, 3), "random");
         if ($urandom_range(0, 7) == 0) go_idle();
      end
      go_idle();
`ifdef DCACHE_PMU_EN
      #1;
      n_checks++;
      if (hit_cnt !== 32'(m_hits) || miss_cnt !== 32'(m_misses)) begin
         n_fail++;
         $display("FAIL pmu_random: hit %0d miss %0d required %0d %0d", hit_cnt, miss_cnt, m_hits, m_misses);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_idle();
      test_directed();
      test_idle();
      test_reset_mid_alloc();
      test_pmu();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
